// File: rtl/wm_stat_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_mon_pkg : cause indices, bit-index helper, event record type       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wm_mon_pkg;

    localparam int WM_IMISS    = 0;
    localparam int WM_OTHER    = 1;
    localparam int WM_STBWAIT  = 2;
    localparam int WM_MUL_WAIT = 3;
    localparam int WM_DIV_WAIT = 4;
    localparam int WM_FP_WAIT  = 5;
    localparam int WM_MUL_BUSY = 6;
    localparam int WM_DIV_BUSY = 7;
    localparam int WM_FP_BUSY  = 8;
    localparam int WM_LDMISS   = 9;

    localparam int WM_NTHR   = 4;
    localparam int WM_NCAUSE = 10;
    localparam int WM_TS_W   = 32;

    typedef struct packed {
        logic [WM_TS_W-1:0]             ts;
        logic [WM_NCAUSE*WM_NTHR-1:0]   vec;
    } wm_evt_t;

    function automatic int bit_idx(input int cause, input int thr, input int nthr = WM_NTHR);
        return cause * nthr + thr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wm_stat_mon_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_stat_mon_if : event record valid/ready channel                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wm_stat_mon_if #(
    parameter int NTHR   = 4,
    parameter int NCAUSE = 10,
    parameter int TS_W   = 32
) ();
    logic                     evt_valid;
    logic                     evt_ready;
    logic [TS_W-1:0]          evt_ts;
    logic [NCAUSE*NTHR-1:0]   evt_vec;

    modport master (output evt_valid, output evt_ts, output evt_vec, input evt_ready);
    modport slave  (input evt_valid, input evt_ts, input evt_vec, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/wm_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_evt_fifo : generic first-word-fall-through synchronous FIFO       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wm_evt_fifo #(
    parameter int  WIDTH = 72,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_l,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == C_DEPTH);
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/wm_stat_mon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wm_stat_mon : per-core wait-mask stall counters and change event log |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wm_stat_mon
    import wm_mon_pkg::*;
#(
    parameter int  NTHR   = 4,
    parameter int  NCAUSE = 10,
    parameter int  CNT_W  = 16,
    parameter int  TS_W   = 32,
    parameter int  DEPTH  = 8,
    localparam int VW     = NCAUSE * NTHR,
    localparam int SEL_W  = $clog2(VW)
) (
    input  wire logic              clk,
    input  wire logic              rst_l,
    input  wire logic              en,
    input  wire logic              clr,
    input  wire logic [VW-1:0]     wait_vec,
    wm_stat_mon_if.master          evt,
    output logic                   ovf,
    output logic      [CNT_W-1:0]  drop_cnt,
    input  wire logic [SEL_W-1:0]  cnt_sel,
    output logic      [CNT_W-1:0]  cnt_data
);
    localparam logic [SEL_W:0] C_VW = (SEL_W+1)'(VW);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [VW-1:0]    old_vec_q, old_vec_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
    logic [CNT_W-1:0] cnt_q [VW];
    logic [CNT_W-1:0] cnt_d [VW];

    logic             chg, drop, fifo_pop, fifo_full, fifo_empty;
    logic [TS_W+VW-1:0] fifo_dout;

    assign chg      = en && (wait_vec != old_vec_q);
    assign fifo_pop = !fifo_empty && evt.evt_ready;
    assign drop     = chg && fifo_full && !fifo_pop;

    wm_evt_fifo #(
        .WIDTH (TS_W + VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (chg),
        .pop   (fifo_pop),
        .din   ({ts_q, wait_vec}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_ts    = fifo_empty ? '0 : fifo_dout[VW +: TS_W];
    assign evt.evt_vec   = fifo_empty ? '0 : fifo_dout[VW-1:0];
    assign ovf           = ovf_q;
    assign drop_cnt      = drop_cnt_q;
    assign cnt_data      = cnt_data_q;

    always_comb begin
        ts_d       = ts_q + 1'b1;
        old_vec_d  = en ? wait_vec : old_vec_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
        for (int i = 0; i < VW; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (en && wait_vec[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Readout captures the pre-update value so it lags the counter by one edge.
        cnt_data_d = '0;
        if ({1'b0, cnt_sel} < C_VW) cnt_data_d = cnt_q[cnt_sel];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ts_q       <= '0;
            old_vec_q  <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            cnt_data_q <= '0;
            for (int i = 0; i < VW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            old_vec_q  <= old_vec_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            cnt_data_q <= cnt_data_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wm_stat_mon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wm_stat_mon : scoreboard bench for the wait-mask monitor          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wm_stat_mon;
    import wm_mon_pkg::*;

    localparam int VW    = 40;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_l, en, clr;
    logic [VW-1:0] wait_vec;
    logic [5:0]    cnt_sel;
    logic          ovf;
    logic [15:0]   drop_cnt, cnt_data;

    always #5 clk = ~clk;

    wm_stat_mon_if #(.NTHR(4), .NCAUSE(10), .TS_W(32)) evt ();

    wm_stat_mon #(
        .NTHR(4), .NCAUSE(10), .CNT_W(16), .TS_W(32), .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .en       (en),
        .clr      (clr),
        .wait_vec (wait_vec),
        .evt      (evt),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .cnt_sel  (cnt_sel),
        .cnt_data (cnt_data)
    );

    int            n_chk  = 0;
    int            n_pass = 0;
    wm_evt_t       sb[$];
    logic [VW-1:0] m_old;
    logic [31:0]   cyc;

    // Reference timestamp: edges seen since reset released.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) cyc <= '0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: validity every cycle, record contents on every pop.
    always @(negedge clk) begin
        if (rst_l === 1'b1) begin
            check("evt_valid", evt.evt_valid, sb.size() != 0);
            if (evt.evt_valid && evt.evt_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_evt", 64'(sb.size()), 64'd1);
                end else begin
                    wm_evt_t e;
                    e = sb.pop_front();
                    check("evt_ts", evt.evt_ts, e.ts);
                    check("evt_vec", evt.evt_vec, e.vec);
                end
            end
        end
    end

    // Apply one cycle of stimulus; the expected record joins the scoreboard once its edge has passed.
    task automatic drive(input logic [VW-1:0] v, input logic e, input logic r, input logic c);
        logic        take;
        logic [31:0] t;
        en = e; wait_vec = v; evt.evt_ready = r; clr = c;
        take = 1'b0;
        t    = cyc;
        if (e && (v != m_old) && ((sb.size() < DEPTH) || r)) take = 1'b1;
        if (e) m_old = v;
        @(posedge clk); #1;
        if (take) sb.push_back('{ts: t, vec: v});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] b38;
        int            i38;

        rst_l = 1'b0; en = 1'b1; clr = 1'b0; wait_vec = 40'h1;
        evt.evt_ready = 1'b0; cnt_sel = '0; m_old = '0;
        #12;
        check("rst_valid", evt.evt_valid, 0);
        check("rst_ts", evt.evt_ts, 0);
        check("rst_vec", evt.evt_vec, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_cnt", cnt_data, 0);

        // First sample after reset.
        @(negedge clk); rst_l = 1'b1;
        repeat (3) drive(40'h1, 1, 0, 0);
        check("first_valid", evt.evt_valid, 1);
        check("first_ts", evt.evt_ts, 0);
        check("first_vec", evt.evt_vec, 40'h1);
        drive(40'h1, 1, 1, 0);
        drive(40'h1, 1, 0, 0);
        check("first_single", evt.evt_valid, 0);

        // Handshake ordering.
        drive(40'h2, 1, 0, 0);
        drive(40'h30, 1, 0, 0);
        drive(40'hAB_CDEF_0123, 1, 0, 0);
        repeat (4) drive(40'hAB_CDEF_0123, 1, 1, 0);
        check("hs_drained", evt.evt_valid, 0);

        // Overflow: 11 changes into an 8-deep FIFO.
        v = 40'hAB_CDEF_0123;
        for (int k = 0; k < 11; k++) begin
            v = v ^ 40'h1;
            drive(v, 1, 0, 0);
        end
        check("ovf_set", ovf, 1);
        check("drop_3", drop_cnt, 3);
        drive(v, 1, 0, 1);
        check("ovf_clr", ovf, 0);
        check("drop_clr", drop_cnt, 0);
        check("still_full", evt.evt_valid, 1);

        // Full FIFO with push and pop on the same edge.
        v = v ^ 40'h1;
        drive(v, 1, 1, 0);
        check("fullpop_ovf", ovf, 0);
        check("fullpop_drop", drop_cnt, 0);
        repeat (9) drive(v, 1, 1, 0);
        check("full_drained", evt.evt_valid, 0);

        // Stall counters.
        i38 = bit_idx(WM_LDMISS, 2);
        b38 = '0;
        b38[i38] = 1'b1;
        drive('0, 1, 1, 1);
        repeat (5) drive(b38, 1, 1, 0);
        cnt_sel = 6'(i38);
        drive('0, 1, 1, 0);
        check("cnt_5", cnt_data, 5);
        repeat (65536 + 3) drive(b38, 1, 1, 0);
        check("cnt_sat", cnt_data, 16'hFFFF);
        drive(b38, 1, 1, 1);
        drive(b38, 1, 1, 0);
        check("cnt_clr_prio", cnt_data, 0);
        drive(b38, 1, 1, 0);
        check("cnt_after_clr", cnt_data, 1);
        cnt_sel = 6'd40;
        drive(b38, 1, 1, 0);
        check("cnt_oob", cnt_data, 0);
        cnt_sel = 6'(i38);

        // en gating.
        drive('0, 1, 1, 1);
        v = b38 | 40'h1;
        repeat (3) drive(v, 0, 1, 0);
        drive(v, 1, 1, 0);
        check("en_nocount", cnt_data, 0);
        drive(v, 1, 1, 0);
        check("en_count", cnt_data, 1);

        // Reset in the middle of an overflowing burst.
        for (int k = 0; k < 10; k++) begin
            v = v ^ 40'h2;
            drive(v, 1, 0, 0);
        end
        check("burst_ovf", ovf, 1);
        check("burst_cnt", cnt_data, 11);
        #2;
        rst_l = 1'b0;
        sb.delete();
        m_old = '0;
        #1;
        check("async_valid", evt.evt_valid, 0);
        check("async_ovf", ovf, 0);
        check("async_cnt", cnt_data, 0);
        check("async_drop", drop_cnt, 0);
        @(negedge clk);
        wait_vec = '0;
        rst_l = 1'b1;
        repeat (3) drive('0, 1, 1, 0);
        check("post_rst_valid", evt.evt_valid, 0);
        check("post_rst_ts", evt.evt_ts, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
